// File: rtl/sys_mon_pkg.sv
// Shared constants and helpers for the LED debug monitor
// and the slow peripherals that reuse its tick generator.
package sys_mon_pkg;

  localparam logic [1:0] MODE_LIVE = 2'd0;
  localparam logic [1:0] MODE_SCAN = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;

  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sys_tick_gen.sv
// Free-running divider: one-cycle registered tick every DIVISOR clocks.
// wrap flags the edge that raises tick, for same-edge consumers.
module sys_tick_gen
  import sys_mon_pkg::*;
#(
  parameter int DIVISOR = 50000000
) (
  input  logic clk,
  input  logic SYS_reset,
  output logic tick,
  output logic wrap
);

  localparam int CW = clog2(DIVISOR + 1);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  assign wrap = (count == LAST);

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= wrap ? '0 : count + 1'b1;
      tick  <= wrap;
    end
  end

endmodule

// File: rtl/sys_led_monitor.sv
// Board debug monitor: picks one of N_CH channels for the LED bank,
// by live select, timed auto-scan, or hold.
module sys_led_monitor
  import sys_mon_pkg::*;
#(
  parameter int DIVISOR = 50000000,
  parameter int N_CH    = 8,
  parameter int DATA_W  = 32,
  parameter int LED_W   = 27
) (
  input  logic                     clk,
  input  logic                     SYS_reset,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [clog2(N_CH)-1:0]   SYS_output_sel,
  input  logic [1:0]               mode,
  output logic                     tick,
  output logic [clog2(N_CH)-1:0]   cur_ch,
  output logic [LED_W-1:0]         SYS_leds
);

  localparam int SEL_W = clog2(N_CH);
  localparam int LO_W  = LED_W - SEL_W;
  localparam logic [SEL_W:0]   N_LIM   = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic              wrap;
  logic [DATA_W-1:0] chans [N_CH];
  logic [DATA_W-1:0] pdata;
  logic [LO_W-1:0]   pfit;
  logic [LO_W-1:0]   snap;
  logic [LO_W-1:0]   snap_n;
  logic [SEL_W-1:0]  cur_n;
  logic [SEL_W-1:0]  nxt;
  logic [SEL_W-1:0]  pick;
  logic              is_scan;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign chans[i] = ch_data[i*DATA_W +: DATA_W];
  end

  sys_tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_tick (
    .clk      (clk),
    .SYS_reset(SYS_reset),
    .tick     (tick),
    .wrap     (wrap)
  );

  assign is_scan = (mode == MODE_SCAN);
  assign nxt     = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
  assign pick    = is_scan ? nxt : SYS_output_sel;
  assign pdata   = chans[pick];

  // LED field narrower than a channel keeps the low bits
  if (DATA_W > LO_W) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^pdata[DATA_W-1:LO_W];
    assign pfit = pdata[LO_W-1:0];
  end else if (DATA_W == LO_W) begin : g_same
    assign pfit = pdata;
  end else begin : g_ext
    assign pfit = {{(LO_W - DATA_W){1'b0}}, pdata};
  end

  always_comb begin
    cur_n  = cur_ch;
    snap_n = snap;
    unique case (1'b1)
      mode == MODE_HOLD: begin
      end
      is_scan: begin
        if (wrap) begin
          cur_n  = nxt;
          snap_n = pfit;
        end
      end
      default: begin
        if ({1'b0, SYS_output_sel} < N_LIM) begin
          cur_n  = SYS_output_sel;
          snap_n = pfit;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      cur_ch <= '0;
      snap   <= '0;
    end else begin
      cur_ch <= cur_n;
      snap   <= snap_n;
    end
  end

  assign SYS_leds = {cur_ch, snap};

endmodule

// File: tb/tb_sys_led_monitor.sv
// Scoreboard bench for sys_led_monitor (DIVISOR=4, N_CH=5)
// plus a DIVISOR=1 instance for the continuous-tick case.
module tb_sys_led_monitor;

  localparam int N_CH = 5;
  localparam int DW   = 32;
  localparam int LW   = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N_CH*DW-1:0] ch_data;
  logic [2:0]        sel;
  logic [1:0]        mode;
  logic              tick, tick1;
  logic [2:0]        cur, cur1;
  logic [LW-1:0]     leds, leds1;

  int checks = 0;
  int errors = 0;
  int n_edges = 0;

  typedef struct {
    string      name;
    logic [29:0] v;
    logic       t;
  } exp_t;

  exp_t q[$];
  exp_t e;

  sys_led_monitor #(
    .DIVISOR(4), .N_CH(N_CH), .DATA_W(DW), .LED_W(LW)
  ) dut (
    .clk(clk), .SYS_reset(rst), .ch_data(ch_data),
    .SYS_output_sel(sel), .mode(mode),
    .tick(tick), .cur_ch(cur), .SYS_leds(leds)
  );

  sys_led_monitor #(
    .DIVISOR(1), .N_CH(N_CH), .DATA_W(DW), .LED_W(LW)
  ) dut1 (
    .clk(clk), .SYS_reset(rst), .ch_data(ch_data),
    .SYS_output_sel(sel), .mode(mode),
    .tick(tick1), .cur_ch(cur1), .SYS_leds(leds1)
  );

  // edges since the last reset edge
  always @(posedge clk) n_edges <= rst ? 0 : n_edges + 1;

  function automatic logic [31:0] chan(input int i);
    return 32'h00A00000 + i * 32'h00111111;
  endfunction

  function automatic logic tick_next();
    return !rst && ((n_edges + 1) % 4 == 0);
  endfunction

  task automatic load_default();
    for (int i = 0; i < N_CH; i++) ch_data[i*DW +: DW] = chan(i);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [26:0] l,
                      input logic [2:0] c);
    exp_t x;
    x.name = nm;
    x.v = {l, c};
    x.t = tick_next();
    q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; sel = 3'd2;
    for (int i = 0; i < 2; i++) begin
      push("reset", 27'h0, 3'd0);
      cyc();
      e = q.pop_front();
      checks++;
      if ({leds, cur, tick, tick1} !== {e.v, e.t, 1'b0}) begin
        errors++;
        $display("FAIL %s got leds=%h cur=%0d tick=%b tick1=%b exp leds=%h cur=%0d tick=%b tick1=0",
                 e.name, leds, cur, tick, tick1, e.v[29:3], e.v[2:0], e.t);
      end
    end
    rst = 1'b0;
    push("reset_release", 27'h2C22222, 3'd2);
    cyc();
    e = q.pop_front();
    checks++;
    if ({leds, cur, tick} !== {e.v, e.t}) begin
      errors++;
      $display("FAIL %s got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
               e.name, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
    end
  endtask

  task automatic test_live();
    sel = 3'd3;
    push("live_sel", 27'h3D33333, 3'd3);
    for (int i = 0; i < 6; i++) begin
      cyc();
      e = q.pop_front();
      checks++;
      if ({leds, cur, tick} !== {e.v, e.t}) begin
        errors++;
        $display("FAIL %s got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
                 e.name, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
      end
      sel = 3'd6;
      if (i < 5) push("live_oor", 27'h3D33333, 3'd3);
    end
  endtask

  task automatic test_divider();
    rst = 1'b1;
    push("div_reset", 27'h0, 3'd0);
    cyc();
    e = q.pop_front();
    checks++;
    if ({leds, cur, tick} !== {e.v, e.t}) begin
      errors++;
      $display("FAIL %s got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
               e.name, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
    end
    rst = 1'b0;
    sel = 3'd6;
    for (int i = 1; i <= 13; i++) begin
      push("div_tick", 27'h0, 3'd0);
      cyc();
      e = q.pop_front();
      checks++;
      if ({leds, cur, tick} !== {e.v, e.t}) begin
        errors++;
        $display("FAIL %s edge %0d got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
                 e.name, i, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
      end
      checks++;
      if (tick1 !== 1'b1) begin
        errors++;
        $display("FAIL div1_tick edge %0d got %b exp 1", i, tick1);
      end
    end
    sel = 3'd3;
    push("div_sel", 27'h3D33333, 3'd3);
    cyc();
    e = q.pop_front();
    checks++;
    if ({leds, cur, tick} !== {e.v, e.t}) begin
      errors++;
      $display("FAIL %s got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
               e.name, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
    end
  endtask

  task automatic test_scan();
    logic [26:0] tbl [4];
    logic [26:0] m;
    int k;
    bit changed;
    tbl[0] = 27'h4E44444;
    tbl[1] = 27'h0A00000;
    tbl[2] = 27'h1B11111;
    tbl[3] = 27'h2C22222;
    m = 27'h3D33333;
    k = 0;
    changed = 0;
    sel = 3'd0;
    mode = 2'd1;
    for (int i = 0; i < 40 && k < 4; i++) begin
      if (tick_next()) begin
        m = tbl[k];
        k++;
      end
      push("scan", m, m[26:24]);
      cyc();
      e = q.pop_front();
      checks++;
      if ({leds, cur, tick} !== {e.v, e.t}) begin
        errors++;
        $display("FAIL %s step %0d got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
                 e.name, i, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
      end
      if (k == 3 && !changed) begin
        ch_data[DW +: DW] = 32'hDEADBEEF;
        changed = 1;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL scan_ticks got %0d exp 4", k);
    end
    load_default();
  endtask

  task automatic test_hold();
    mode = 2'd2;
    for (int i = 0; i < 20; i++) begin
      sel = 3'($urandom_range(0, 7));
      for (int j = 0; j < N_CH; j++) ch_data[j*DW +: DW] = $urandom;
      push("hold", 27'h2C22222, 3'd2);
      cyc();
      e = q.pop_front();
      checks++;
      if ({leds, cur, tick} !== {e.v, e.t}) begin
        errors++;
        $display("FAIL %s step %0d got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
                 e.name, i, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
      end
    end
    load_default();
  endtask

  task automatic test_mode3();
    mode = 2'd3;
    sel = 3'd4;
    push("mode3_sel", 27'h4E44444, 3'd4);
    cyc();
    sel = 3'd7;
    push("mode3_oor", 27'h4E44444, 3'd4);
    for (int i = 0; i < 2; i++) begin
      e = q.pop_front();
      checks++;
      if ({leds, cur, tick} !== {e.v, e.t}) begin
        errors++;
        $display("FAIL %s got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
                 e.name, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
      end
      if (i == 0) cyc();
    end
  endtask

  task automatic test_reset_scan();
    mode = 2'd1;
    for (int i = 0; i < 8 && !tick_next(); i++) cyc();
    checks++;
    if (!tick_next()) begin
      errors++;
      $display("FAIL rscan_find_wrap got none exp wrap within 8");
    end
    rst = 1'b1;
    push("rscan_reset", 27'h0, 3'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      e = q.pop_front();
      checks++;
      if ({leds, cur, tick} !== {e.v, e.t}) begin
        errors++;
        $display("FAIL %s got leds=%h cur=%0d tick=%b exp leds=%h cur=%0d tick=%b",
                 e.name, leds, cur, tick, e.v[29:3], e.v[2:0], e.t);
      end
      if (i < 4) begin
        if (i == 3) push("rscan_tick", 27'h1B11111, 3'd1);
        else push("rscan_wait", 27'h0, 3'd0);
        cyc();
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    sel = 3'd2;
    load_default();
    test_reset();
    test_live();
    test_divider();
    test_scan();
    test_hold();
    test_mode3();
    test_reset_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
